vec_flow_queue: RTL and testbench
=================================

# vec_flow_queue

Parametrised, mode-selectable val/rdy FIFO for the vector coprocessor datapath, replacing the fixed single-mode queue wherever lanes, the load/store unit or the instruction front end need buffering. It supports arbitrary (non-power-of-two) depth and an occupancy count with an almost-full flag for credit/back-pressure logic. It also offers a synchronous flush for squashing in-flight vector ops, plus normal, bypass and pipe flow modes selected at elaboration.

## Interface
Parameters:
- WIDTH, 8: payload bits per entry (≥1).
- DEPTH, 16: number of entries (≥2, any integer).
- MODE, 0: 0 = normal, 1 = bypass, 2 = pipe.
- AFULL_THRESH, DEPTH-1: count at or above which almost_full asserts (1..DEPTH).
- CW: derived, $clog2(DEPTH+1); not user-set.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous clear of all entries.
- recv_msg  in  WIDTH  enqueue payload.
- recv_val  in  1  enqueue valid.
- recv_rdy  out  1  enqueue ready.
- send_msg  out  WIDTH  dequeue payload (head entry, or recv_msg on bypass).
- send_val  out  1  dequeue valid.
- send_rdy  in  1  dequeue ready.
- count  out  CW  current occupancy, 0..DEPTH.
- almost_full  out  1  count ≥ AFULL_THRESH.

## Operation
- State: storage array [DEPTH], head and tail pointers (0..DEPTH-1), count register. Full = (count == DEPTH); empty = (count == 0).
- Pointers advance by one and wrap explicitly from DEPTH-1 to 0. Power-of-two overflow is never relied on.
- Enqueue fire = recv_val & recv_rdy: write recv_msg at tail, advance tail. Dequeue fire = send_val & send_rdy: advance head.
- count next = count + enq_stored − deq_stored. Both firing at once leaves count unchanged.
- MODE 0 (normal):
  - recv_rdy = !full & !flush.
  - send_val = !empty & !flush.
  - send_msg = mem[head].
- MODE 1 (bypass):
  - As normal, except when empty & !flush: send_val = recv_val and send_msg = recv_msg.
  - A bypass transfer (empty, recv_val, send_rdy) is not written into storage. Pointers and count are unchanged.
  - When empty & recv_val & !send_rdy, the message is stored normally.
- MODE 2 (pipe):
  - recv_rdy = (!full | send_rdy) & !flush.
  - When full, a same-cycle dequeue frees the slot for the enqueue.
  - send_val and send_msg behave as in normal mode.
- Flush:
  - While flush=1, recv_rdy=0 and send_val=0, so no transfer fires.
  - At the next edge: head=tail=0, count=0.
  - Flush overrides all other activity.
- Stored data is not cleared by reset or flush. Only pointers and count are cleared.
- send_msg is don't-care whenever send_val=0.

## Timing
- Reset:
  - While reset is high: count=0, almost_full=0, recv_rdy=0, send_val=0. Pointers are 0.
  - First cycle after deassert: recv_rdy=1, and send_val=0 except through bypass.
  - Reset asserted mid-operation discards all contents asynchronously.
- Latency:
  - Normal and pipe: an entry enqueued at edge N is visible on send_val/send_msg in cycle N+1.
  - Bypass: 0 cycles when empty.
- Throughput: one enqueue and one dequeue per cycle in every mode.
- Full boundary:
  - Normal/bypass: recv_rdy=0 when count==DEPTH, regardless of send_rdy.
  - Pipe: recv_rdy follows send_rdy when full. This is a combinational send_rdy→recv_rdy path.
- Empty boundary: send_val=0 in normal/pipe. In bypass, send_val follows recv_val.
- count and almost_full are registered-state functions. They carry no combinational input path.

## Test plan
- Reset/fill/drain:
  - Setup: DEPTH=3, MODE 0.
  - Stimulus: after reset deassert, enqueue 0x11, 0x22, 0x33 with send_rdy=0.
  - Required: count=3, recv_rdy=0 and almost_full=1 (thresh 2) after the 3rd edge.
  - Then drain with send_rdy=1. Required: send_msg sequence 0x11, 0x22, 0x33, count back to 0, send_val=0.
- Wrap-around:
  - Setup: DEPTH=3.
  - Stimulus: 10 back-to-back simultaneous enq/deq with payloads 1..10 and one entry pre-loaded.
  - Required: count stays 1, output order is preserved, and pointers cross index 2→0 at least three times.
- Bypass:
  - Setup: MODE 1, empty.
  - Stimulus: recv_val=1, recv_msg=0xA5, send_rdy=1.
  - Required: send_val=1 and send_msg=0xA5 the same cycle, count stays 0.
  - Same stimulus with send_rdy=0. Required: stored, count=1 next cycle.
- Pipe full:
  - Setup: MODE 2, DEPTH=2, full with 0x01, 0x02.
  - Stimulus: send_rdy=1, recv_val=1, recv_msg=0x03.
  - Required: recv_rdy=1, both fire, count stays 2, next outputs 0x02 then 0x03.
  - Same setup in MODE 0. Required: recv_rdy=0.
- Flush priority:
  - Setup: count=2.
  - Stimulus: flush=1 with recv_val=1 and send_rdy=1.
  - Required: recv_rdy=0 and send_val=0 that cycle, count=0 next cycle. A subsequent enqueue of 0x7E is the next output.
- Async reset mid-stream:
  - Setup: count=2.
  - Stimulus: assert reset between clock edges.
  - Required: count=0, recv_rdy=0 and send_val=0 immediately (before the next edge). Normal operation resumes after deassert.

Source files
------------

// File: rtl/vec_flow_queue.sv
// vec_flow_queue: parametrised val/rdy FIFO with arbitrary depth, occupancy
// count, almost-full flag, synchronous flush and an elaboration-time flow mode.
//
// Parameters:
//   WIDTH        payload bits per entry
//   DEPTH        number of entries (any integer >= 2)
//   MODE         0 = normal, 1 = bypass (empty queue passes recv straight to send),
//                2 = pipe (a full queue accepts when the head is leaving this cycle)
//   AFULL_THRESH occupancy at or above which almost_full asserts
//   CW           derived count width, holds 0..DEPTH
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   flush               synchronous clear of all entries, blocks all transfers
//   recv_msg/val/rdy    enqueue side
//   send_msg/val/rdy    dequeue side
//   count               current occupancy
//   almost_full         count >= AFULL_THRESH
module vec_flow_queue #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned MODE         = 0,
  parameter int unsigned AFULL_THRESH = DEPTH - 1,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [WIDTH-1:0] send_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int unsigned    PW        = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AFULL_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic full_s;
  logic empty_s;
  logic enq_fire_s;
  logic deq_fire_s;
  logic bypass_s;
  logic enq_store_s;
  logic deq_store_s;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Handshake outputs and transfer qualification for the selected flow mode.
  always_comb begin
    full_s   = (count_q == DEPTH_CNT);
    empty_s  = (count_q == {CW{1'b0}});
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = mem_q[head_q];

    // Reset gates the handshakes combinationally so nothing fires while it is held.
    case (MODE)
      32'd2:   recv_rdy = (!full_s || send_rdy) && !flush && !reset;
      default: recv_rdy = !full_s && !flush && !reset;
    endcase

    if ((MODE == 32'd1) && empty_s) begin
      send_val = recv_val && !flush && !reset;
      send_msg = recv_msg;
    end else begin
      send_val = !empty_s && !flush && !reset;
      send_msg = mem_q[head_q];
    end

    enq_fire_s  = recv_val && recv_rdy;
    deq_fire_s  = send_val && send_rdy;
    // A message passing straight through an empty bypass queue never touches storage.
    bypass_s    = (MODE == 32'd1) && empty_s && enq_fire_s && deq_fire_s;
    enq_store_s = enq_fire_s && !bypass_s;
    deq_store_s = deq_fire_s && !bypass_s;
  end

  // Next-state for pointers and occupancy; flush wins over any transfer.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (enq_store_s) begin
        tail_d = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (deq_store_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      case ({enq_store_s, deq_store_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents survive reset and flush since pointers define validity.
  always_ff @(posedge clk) begin
    if (enq_store_s) begin
      mem_q[tail_q] <= recv_msg;
    end
  end

  assign count       = count_q;
  assign almost_full = (count_q >= AF_CNT);

endmodule

// File: tb/tb_vec_flow_queue.sv
// Self-checking bench for vec_flow_queue. Four instances cover normal (DEPTH 3),
// bypass (DEPTH 5), pipe (DEPTH 2) and normal (DEPTH 2). A queue-based model per
// instance predicts every output each cycle; directed sequences pin key values.
module tb_vec_flow_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rv [4];
  logic       srdy [4];
  logic       fl [4];
  logic [7:0] rm [4];
  logic       rr [4];
  logic       sv [4];
  logic       af [4];
  logic [7:0] sm [4];
  logic [1:0] c0;
  logic [2:0] c1;
  logic [1:0] c2;
  logic [1:0] c3;
  logic [3:0] cnt [4];

  int depth_m [4] = '{3, 5, 2, 2};
  int mode_m  [4] = '{0, 1, 2, 0};
  int thr_m   [4] = '{2, 4, 1, 1};

  logic [7:0] mq [4][$];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vec_flow_queue #(.WIDTH(8), .DEPTH(3), .MODE(0), .AFULL_THRESH(2)) d0 (
    .clk(clk), .reset(reset), .flush(fl[0]), .recv_msg(rm[0]), .recv_val(rv[0]),
    .recv_rdy(rr[0]), .send_msg(sm[0]), .send_val(sv[0]), .send_rdy(srdy[0]),
    .count(c0), .almost_full(af[0]));
  vec_flow_queue #(.WIDTH(8), .DEPTH(5), .MODE(1)) d1 (
    .clk(clk), .reset(reset), .flush(fl[1]), .recv_msg(rm[1]), .recv_val(rv[1]),
    .recv_rdy(rr[1]), .send_msg(sm[1]), .send_val(sv[1]), .send_rdy(srdy[1]),
    .count(c1), .almost_full(af[1]));
  vec_flow_queue #(.WIDTH(8), .DEPTH(2), .MODE(2)) d2 (
    .clk(clk), .reset(reset), .flush(fl[2]), .recv_msg(rm[2]), .recv_val(rv[2]),
    .recv_rdy(rr[2]), .send_msg(sm[2]), .send_val(sv[2]), .send_rdy(srdy[2]),
    .count(c2), .almost_full(af[2]));
  vec_flow_queue #(.WIDTH(8), .DEPTH(2), .MODE(0)) d3 (
    .clk(clk), .reset(reset), .flush(fl[3]), .recv_msg(rm[3]), .recv_val(rv[3]),
    .recv_rdy(rr[3]), .send_msg(sm[3]), .send_val(sv[3]), .send_rdy(srdy[3]),
    .count(c3), .almost_full(af[3]));

  assign cnt[0] = {2'b00, c0};
  assign cnt[1] = {1'b0, c1};
  assign cnt[2] = {2'b00, c2};
  assign cnt[3] = {2'b00, c3};

  // Model: expected handshakes from occupancy and current inputs.
  function automatic logic exp_rr(int i);
    return !reset && !fl[i] &&
           ((mq[i].size() < depth_m[i]) || (mode_m[i] == 2 && srdy[i]));
  endfunction

  function automatic logic exp_sv(int i);
    return !reset && !fl[i] && ((mq[i].size() > 0) || (mode_m[i] == 1 && rv[i]));
  endfunction

  // Model state update: transfers at each edge, cleared by reset or flush.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 4; i++) begin
      logic e;
      logic d;
      if (reset) begin
        mq[i].delete();
      end else if (fl[i]) begin
        mq[i].delete();
      end else begin
        e = rv[i] && exp_rr(i);
        d = exp_sv(i) && srdy[i];
        if (!(mq[i].size() == 0 && e && d)) begin
          if (d) void'(mq[i].pop_front());
          if (e) mq[i].push_back(rm[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", name, i, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      chk("recv_rdy", i, {31'd0, rr[i]}, {31'd0, exp_rr(i)});
      chk("send_val", i, {31'd0, sv[i]}, {31'd0, exp_sv(i)});
      chk("count", i, {28'd0, cnt[i]}, mq[i].size());
      chk("almost_full", i, {31'd0, af[i]}, (mq[i].size() >= thr_m[i]) ? 32'd1 : 32'd0);
      if (exp_sv(i)) begin
        chk("send_msg", i, {24'd0, sm[i]},
            {24'd0, (mq[i].size() > 0) ? mq[i][0] : rm[i]});
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic tick();
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    half();
    tick();
  endtask

  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      rv[i] = 1'b0; srdy[i] = 1'b0; fl[i] = 1'b0; rm[i] = 8'h00;
    end
  endtask

  logic [7:0] fill_v [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    idle();
    #12;
    chk("rst_count", 0, {30'd0, c0}, 32'd0);
    chk("rst_recv_rdy", 0, {31'd0, rr[0]}, 32'd0);
    chk("rst_send_val", 0, {31'd0, sv[0]}, 32'd0);
    chk("rst_afull", 0, {31'd0, af[0]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    half();
    chk("post_rst_rdy", 0, {31'd0, rr[0]}, 32'd1);
    chk("post_rst_val", 0, {31'd0, sv[0]}, 32'd0);
    tick();

    // Fill DEPTH 3 normal queue, then drain.
    for (int k = 0; k < 3; k++) begin
      rv[0] = 1'b1; rm[0] = fill_v[k];
      cycle();
    end
    rv[0] = 1'b0;
    half();
    chk("fill_count", 0, {30'd0, c0}, 32'd3);
    chk("fill_rdy", 0, {31'd0, rr[0]}, 32'd0);
    chk("fill_afull", 0, {31'd0, af[0]}, 32'd1);
    tick();
    srdy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      half();
      chk("drain_val", 0, {31'd0, sv[0]}, 32'd1);
      chk("drain_msg", 0, {24'd0, sm[0]}, {24'd0, fill_v[k]});
      tick();
    end
    half();
    chk("drained_count", 0, {30'd0, c0}, 32'd0);
    chk("drained_val", 0, {31'd0, sv[0]}, 32'd0);
    tick();
    srdy[0] = 1'b0;

    // Wrap-around: one pre-loaded entry then 10 simultaneous enq/deq.
    rv[0] = 1'b1; rm[0] = 8'h00;
    cycle();
    srdy[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      rm[0] = 8'(k);
      half();
      chk("wrap_count", 0, {30'd0, c0}, 32'd1);
      chk("wrap_msg", 0, {24'd0, sm[0]}, k - 1);
      tick();
    end
    rv[0] = 1'b0;
    half();
    chk("wrap_last", 0, {24'd0, sm[0]}, 32'd10);
    tick();
    srdy[0] = 1'b0;

    // Bypass on empty queue, then store when send side stalls.
    rv[1] = 1'b1; rm[1] = 8'hA5; srdy[1] = 1'b1;
    half();
    chk("byp_val", 1, {31'd0, sv[1]}, 32'd1);
    chk("byp_msg", 1, {24'd0, sm[1]}, 32'hA5);
    tick();
    rv[1] = 1'b0;
    half();
    chk("byp_count", 1, {29'd0, c1}, 32'd0);
    tick();
    rv[1] = 1'b1; srdy[1] = 1'b0;
    cycle();
    rv[1] = 1'b0;
    half();
    chk("byp_stored", 1, {29'd0, c1}, 32'd1);
    chk("byp_stored_msg", 1, {24'd0, sm[1]}, 32'hA5);
    tick();
    srdy[1] = 1'b1;
    cycle();
    srdy[1] = 1'b0;

    // Pipe vs normal at full with a simultaneous dequeue.
    for (int k = 1; k <= 2; k++) begin
      rv[2] = 1'b1; rv[3] = 1'b1; rm[2] = 8'(k); rm[3] = 8'(k);
      cycle();
    end
    rm[2] = 8'h03; rm[3] = 8'h03; srdy[2] = 1'b1; srdy[3] = 1'b1;
    half();
    chk("pipe_rdy", 2, {31'd0, rr[2]}, 32'd1);
    chk("normal_full_rdy", 3, {31'd0, rr[3]}, 32'd0);
    tick();
    rv[2] = 1'b0; rv[3] = 1'b0; srdy[2] = 1'b0; srdy[3] = 1'b0;
    half();
    chk("pipe_count", 2, {30'd0, c2}, 32'd2);
    chk("pipe_head", 2, {24'd0, sm[2]}, 32'h02);
    chk("normal_count", 3, {30'd0, c3}, 32'd1);
    tick();
    srdy[2] = 1'b1; srdy[3] = 1'b1;
    cycle();
    half();
    chk("pipe_next", 2, {24'd0, sm[2]}, 32'h03);
    tick();
    cycle();
    srdy[2] = 1'b0; srdy[3] = 1'b0;

    // Flush priority.
    rv[0] = 1'b1; rm[0] = 8'h55;
    cycle();
    rm[0] = 8'h66;
    cycle();
    rm[0] = 8'h77; fl[0] = 1'b1; srdy[0] = 1'b1;
    half();
    chk("flush_rdy", 0, {31'd0, rr[0]}, 32'd0);
    chk("flush_val", 0, {31'd0, sv[0]}, 32'd0);
    tick();
    fl[0] = 1'b0; rv[0] = 1'b0; srdy[0] = 1'b0;
    half();
    chk("flush_count", 0, {30'd0, c0}, 32'd0);
    tick();
    rv[0] = 1'b1; rm[0] = 8'h7E;
    cycle();
    rv[0] = 1'b0;
    half();
    chk("post_flush_msg", 0, {24'd0, sm[0]}, 32'h7E);
    tick();
    srdy[0] = 1'b1;
    cycle();
    srdy[0] = 1'b0;

    // Asynchronous reset between edges.
    rv[0] = 1'b1; rm[0] = 8'h12;
    cycle();
    rm[0] = 8'h34;
    cycle();
    rv[0] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", 0, {30'd0, c0}, 32'd0);
    chk("async_rdy", 0, {31'd0, rr[0]}, 32'd0);
    chk("async_val", 0, {31'd0, sv[0]}, 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    half();
    chk("resume_rdy", 0, {31'd0, rr[0]}, 32'd1);
    tick();
    rv[0] = 1'b1; rm[0] = 8'h99;
    cycle();
    rv[0] = 1'b0;
    half();
    chk("resume_msg", 0, {24'd0, sm[0]}, 32'h99);
    tick();

    // Randomized traffic with alternating fill/drain bias.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        rv[i]   = ($urandom % 4) != 0;
        srdy[i] = ((n / 200) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
        fl[i]   = ($urandom % 40) == 0;
        rm[i]   = 8'($urandom);
      end
      reset = ($urandom % 700) == 0;
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
